// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg: shared divider op encodings, FSM states and latency         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int DIV_XLEN           = 32;
  localparam int DIV_BITS_PER_CYCLE = 4;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_CALC = 2'd1,
    DIV_ST_FIX  = 2'd2
  } div_state_e;

  // One load cycle is folded into the iteration count; FIX adds the +1.
  function automatic int div_latency(input int xlen, input int bpc);
    return xlen / bpc + 1;
  endfunction

  localparam int DIV_LATENCY = div_latency(DIV_XLEN, DIV_BITS_PER_CYCLE);

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_step: BITS_PER_CYCLE unrolled restoring division steps           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module div_step #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic [XLEN:0]   i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN:0]   o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0]   w_rem [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] w_quo [BITS_PER_CYCLE+1];

  assign w_rem[0] = i_rem;
  assign w_quo[0] = i_quo;

  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    logic [XLEN+1:0] w_shift;
    logic [XLEN+1:0] w_diff;

    // Extra headroom bit makes the borrow of the trial subtract visible as the MSB.
    assign w_shift      = {w_rem[k], w_quo[k][XLEN-1]};
    assign w_diff       = w_shift - {2'b00, i_divisor};
    assign w_rem[k+1]   = w_diff[XLEN+1] ? w_shift[XLEN:0] : w_diff[XLEN:0];
    assign w_quo[k+1]   = {w_quo[k][XLEN-2:0], ~w_diff[XLEN+1]};
  end

  assign o_rem = w_rem[BITS_PER_CYCLE];
  assign o_quo = w_quo[BITS_PER_CYCLE];

endmodule
`default_nettype wire

// File: rtl/iter_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iter_divider: fixed-latency RV32M DIV/DIVU/REM/REMU iterative unit   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module iter_divider
  import cpu_pkg::*;
#(
  parameter int XLEN           = DIV_XLEN,
  parameter int BITS_PER_CYCLE = DIV_BITS_PER_CYCLE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int ITERS   = XLEN / BITS_PER_CYCLE;
  localparam int LATENCY = div_latency(XLEN, BITS_PER_CYCLE);
  localparam int CNT_W   = $clog2(LATENCY);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e        r_state;
  div_state_e        w_state_next;
  logic              w_load;
  logic              w_finish;

  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_dividend;
  logic [XLEN-1:0]   r_divisor;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN:0]     r_rem;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_q_neg;
  logic              r_r_neg;
  logic              r_div0;
  logic              r_ovf;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN:0]     w_rem_next;
  logic [XLEN-1:0]   w_quo_next;
  logic              w_is_rem;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_result;
  logic              w_unused_rem_msb;

  // Operand conditioning; abs(MIN_NEG) wraps to itself, which is 2^(XLEN-1) unsigned.
  assign w_signed = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  assign w_a_neg  = w_signed & dividend[XLEN-1];
  assign w_b_neg  = w_signed & divisor[XLEN-1];
  assign w_a_mag  = w_a_neg ? -dividend : dividend;
  assign w_b_mag  = w_b_neg ? -divisor  : divisor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= DIV_ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      DIV_ST_IDLE: begin
        if (start && !abort) begin
          w_state_next = DIV_ST_CALC;
          w_load       = 1'b1;
        end
      end
      DIV_ST_CALC: begin
        if (abort)                        w_state_next = DIV_ST_IDLE;
        else if (r_cnt == CNT_W'(1))      w_state_next = DIV_ST_FIX;
      end
      DIV_ST_FIX: begin
        w_state_next = DIV_ST_IDLE;
        w_finish     = !abort;
      end
      default: w_state_next = DIV_ST_IDLE;
    endcase
  end

  div_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_div_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_quo     (w_quo_next)
  );

  assign w_is_rem  = (r_op == DIV_OP_REM) || (r_op == DIV_OP_REMU);
  assign w_quo_fix = r_q_neg ? -r_quo : r_quo;
  assign w_rem_fix = r_r_neg ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
  assign w_unused_rem_msb = r_rem[XLEN];

  always_comb begin
    w_result = w_is_rem ? w_rem_fix : w_quo_fix;
    if (r_div0)     w_result = w_is_rem ? r_dividend : '1;
    else if (r_ovf) w_result = w_is_rem ? '0 : r_dividend;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op       <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_div0     <= 1'b0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_op       <= op;
        r_dividend <= dividend;
        r_divisor  <= w_b_mag;
        r_quo      <= w_a_mag;
        r_rem      <= '0;
        r_cnt      <= CNT_W'(ITERS);
        r_q_neg    <= w_a_neg ^ w_b_neg;
        r_r_neg    <= w_a_neg;
        r_div0     <= (divisor == '0);
        r_ovf      <= w_signed && (dividend == MIN_NEG) && (divisor == '1);
      end else if (r_state == DIV_ST_CALC) begin
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_finish) r_result <= w_result;
    end
  end

  assign busy   = (r_state != DIV_ST_IDLE);
  assign done   = r_done;
  assign result = r_result;

endmodule
`default_nettype wire
